// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: LOAD/RUN/DONE sequencer for the iterative multiply/divide datapath.
// Optional macro SEQ_CTRL_EARLY_EXIT_EN: multiplies stop once rem_zero reports no multiplier bits left.
module alu_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             op,
  input  logic             divisor_zero,
  input  logic             rem_zero,
  output logic             ready,
  output logic             load,
  output logic             step,
  output logic             op_div,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic             exception
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, next;
  logic err, early, last;
`ifdef SEQ_CTRL_EARLY_EXIT_EN
  assign early = state == RUN && !op_div && rem_zero;
`else
  logic unused_rem;
  assign unused_rem = rem_zero;
  assign early = 1'b0;
`endif
  assign last = count == CNT_W'(WIDTH - 1);
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = start ? ((op && divisor_zero) ? DONE : LOAD) : IDLE;
      LOAD: next = RUN;
      RUN:  next = (early || last) ? DONE : RUN;
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    ready = state == IDLE;
    load = state == LOAD;
    step = state == RUN && !early;
    done = state == DONE;
    exception = done && err;
  end
  // count saturates at the terminal index; early exit freezes it because step drops
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      count <= '0;
      op_div <= 1'b0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        op_div <= op;
        err <= op && divisor_zero;
      end
      if (state == DONE) begin
        op_div <= 1'b0;
        err <= 1'b0;
      end
      if (state == LOAD) count <= '0;
      else if (step && !last) count <= count + 1'b1;
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: table-driven scoreboard bench for alu_seq_ctrl (latency, strobes, busy, reset abort).
module tb_alu_seq_ctrl;
  logic clock = 1'b0, resetn = 1'b0, start = 1'b0, op = 1'b0, divisor_zero = 1'b0, rem_zero = 1'b0;
  logic ready, load, step, op_div, done, exception;
  logic [4:0] count;
  int total = 0, bad = 0;

  typedef struct {
    logic o, dz;
    int rz_at, abort_at;
    bit busy;
    int lat, exc, steps, loads, cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  alu_seq_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clock(clock), .resetn(resetn), .start(start), .op(op), .divisor_zero(divisor_zero),
    .rem_zero(rem_zero), .ready(ready), .load(load), .step(step), .op_div(op_div),
    .count(count), .done(done), .exception(exception)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, int'(ready), 1);
    chk({tag, "_load"}, int'(load), 0);
    chk({tag, "_step"}, int'(step), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_exc"}, int'(exception), 0);
    chk({tag, "_opdiv"}, int'(op_div), 0);
    chk({tag, "_count"}, int'(count), 0);
  endtask

  task automatic run_op(input vec_t v);
    vec_t e;
    int lat = 0, steps = 0, loads = 0;
    bit fin = 0, aborted = 0;
    @(negedge clock);
    start = 1'b1; op = v.o; divisor_zero = v.dz; rem_zero = 1'b0;
    #1 chk("ready_before_start", int'(ready), 1);
    sb.push_back(v);
    while (!fin && lat < 100) begin
      @(negedge clock);
      lat++;
      start = v.busy;
      op = ~v.o;
      divisor_zero = ~v.dz;
      rem_zero = v.rz_at >= 0 && lat >= 2 && int'(count) == v.rz_at;
      #1;
      if (v.abort_at >= 0 && step && int'(count) == v.abort_at) begin
        resetn = 1'b0;
        start = 1'b0;
        rem_zero = 1'b0;
        #1 chk_reset_vals("abort");
        void'(sb.pop_back());
        aborted = 1;
        fin = 1;
      end else begin
        if (load) begin
          loads++;
          chk("load_latency", lat, 1);
        end
        if (step) begin
          chk("step_count", int'(count), steps);
          steps++;
        end
        if (done) begin
          fin = 1;
          chk("op_div_at_done", int'(op_div), int'(v.o));
          if (sb.size() == 0) chk("sb_empty_at_done", 0, 1);
          else begin
            e = sb.pop_front();
            chk("done_latency", lat, e.lat);
            chk("exception", int'(exception), e.exc);
            chk("step_total", steps, e.steps);
            chk("load_total", loads, e.loads);
            if (e.cnt >= 0) chk("count_at_done", int'(count), e.cnt);
          end
        end
      end
    end
    if (!fin) chk("done_timeout", lat, v.lat);
    if (aborted) begin
      repeat (3) begin
        @(negedge clock);
        #1 chk("no_done_in_reset", int'(done), 0);
      end
      @(negedge clock);
      resetn = 1'b1;
    end else begin
      @(negedge clock);
      start = 1'b0;
      #1 chk("ready_after_done", int'(ready), 1);
      chk("no_done_after", int'(done), 0);
      @(negedge clock);
      #1 chk("no_queued_start", int'(load) | int'(done), 0);
      chk("still_ready", int'(ready), 1);
    end
  endtask

  function automatic vec_t mk(input logic o, dz, input int rz_at, abort_at, input bit busy,
                              input int lat, exc, steps, loads, cnt);
    vec_t v;
    v.o = o; v.dz = dz; v.rz_at = rz_at; v.abort_at = abort_at; v.busy = busy;
    v.lat = lat; v.exc = exc; v.steps = steps; v.loads = loads; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    vecs.push_back(mk(0, 0, -1, -1, 0, 34, 0, 32, 1, 31));
    vecs.push_back(mk(1, 0, -1, -1, 0, 34, 0, 32, 1, 31));
    vecs.push_back(mk(0, 1, -1, -1, 0, 34, 0, 32, 1, 31));
    vecs.push_back(mk(1, 1, -1, -1, 0, 1, 1, 0, 0, -1));
    vecs.push_back(mk(0, 0, -1, -1, 1, 34, 0, 32, 1, 31));
    vecs.push_back(mk(1, 1, -1, -1, 1, 1, 1, 0, 0, -1));
`ifdef SEQ_CTRL_EARLY_EXIT_EN
    vecs.push_back(mk(0, 0, 5, -1, 0, 8, 0, 5, 1, 5));
`else
    vecs.push_back(mk(0, 0, 5, -1, 0, 34, 0, 32, 1, 31));
`endif
    vecs.push_back(mk(1, 0, 5, -1, 0, 34, 0, 32, 1, 31));
    start = 1'b1;
    repeat (2) @(negedge clock);
    #1 chk_reset_vals("reset");
    start = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    #1 chk("idle_ready", int'(ready), 1);
    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i]);
    run_op(mk(0, 0, -1, 10, 0, 34, 0, 32, 1, 31));
    chk("sb_drained_after_abort", sb.size(), 0);
    run_op(mk(0, 0, -1, -1, 0, 34, 0, 32, 1, 31));
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
